// File: rtl/dsm_tx_sched.sv
// Transmit sample scheduler: buffers upstream samples in a FIFO.
// It releases one sample per RATIO clocks and drives the fs/4 LO.
module dsm_tx_sched #(
  parameter int DW        = 20,
  parameter int RATIO     = 50,
  parameter int DEPTH     = 4,
  parameter int PRIME_LVL = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       flush,
  input  logic [DW-1:0]              in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [DW-1:0]              v_out,
  output logic                       sample_stb,
  output logic [1:0]                 LO,
  output logic                       running,
  output logic                       underflow,
  output logic [7:0]                 under_cnt,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int PW = $clog2(RATIO);
  localparam logic [PW-1:0] PH_LAST = PW'(RATIO - 1);
  localparam logic [LW-1:0] FULL    = LW'(DEPTH);
  localparam logic [LW-1:0] PRIME_N = LW'(PRIME_LVL);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRIME,
    S_RUN
  } state_t;

  state_t          state_q, state_d;
  logic [LW-1:0]   count_q, count_d;
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [PW-1:0]   phase_q, phase_d;
  logic [1:0]      lo_cnt_q, lo_cnt_d;
  logic [1:0]      lo_q, lo_d;
  logic [DW-1:0]   vout_q, vout_d;
  logic            stb_q, stb_d;
  logic            uf_q, uf_d;
  logic [7:0]      ucnt_q, ucnt_d;
  logic [DW-1:0]   mem_q [DEPTH];

  logic ph_wrap, enter, leave, keep;
  logic do_flush, push, pop;

  assign in_ready   = (count_q != FULL);
  assign running    = (state_q == S_RUN);
  assign level      = count_q;
  assign v_out      = vout_q;
  assign sample_stb = stb_q;
  assign LO         = lo_q;
  assign underflow  = uf_q;
  assign under_cnt  = ucnt_q;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    phase_d  = phase_q;
    lo_cnt_d = lo_cnt_q;
    lo_d     = 2'b00;
    vout_d   = vout_q;
    stb_d    = 1'b0;
    uf_d     = uf_q;
    ucnt_d   = ucnt_q;

    ph_wrap  = (phase_q == PH_LAST);
    enter    = (state_q == S_PRIME) && enable
             && (count_q >= PRIME_N);
    leave    = (state_q == S_RUN) && ph_wrap && !enable;
    keep     = enter
             || ((state_q == S_RUN) && ph_wrap && enable);
    do_flush = flush && (state_q == S_IDLE);
    push     = in_valid && in_ready && !do_flush;
    pop      = keep && (count_q != '0);

    unique case (state_q)
      S_IDLE:  if (enable) state_d = S_PRIME;
      S_PRIME: begin
        if (!enable)    state_d = S_IDLE;
        else if (enter) state_d = S_RUN;
      end
      S_RUN:   if (leave) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (do_flush) begin
      count_d = '0;
      wptr_d  = '0;
      rptr_d  = '0;
      uf_d    = 1'b0;
    end else begin
      count_d = count_q + LW'(push) - LW'(pop);
      if (push) wptr_d = wptr_q + 1'b1;
      if (pop)  rptr_d = rptr_q + 1'b1;
    end

    if (enter || leave) begin
      phase_d  = '0;
      lo_cnt_d = '0;
    end else if (state_q == S_RUN) begin
      phase_d  = ph_wrap ? '0 : phase_q + 1'b1;
      lo_cnt_d = lo_cnt_q + 1'b1;
    end

    if (state_d == S_RUN) begin
      unique case (lo_cnt_d)
        2'd0:    lo_d = 2'b01;
        2'd2:    lo_d = 2'b10;
        default: lo_d = 2'b00;
      endcase
    end

    // An empty FIFO at a frame load mutes the output and is logged.
    if (keep) begin
      stb_d = 1'b1;
      if (pop) begin
        vout_d = mem_q[rptr_q];
      end else begin
        vout_d = '0;
        uf_d   = 1'b1;
        if (ucnt_q != 8'hff) ucnt_d = ucnt_q + 8'd1;
      end
    end else if (leave) begin
      vout_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wptr_q] <= in_data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      phase_q  <= '0;
      lo_cnt_q <= '0;
      lo_q     <= 2'b00;
      vout_q   <= '0;
      stb_q    <= 1'b0;
      uf_q     <= 1'b0;
      ucnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      phase_q  <= phase_d;
      lo_cnt_q <= lo_cnt_d;
      lo_q     <= lo_d;
      vout_q   <= vout_d;
      stb_q    <= stb_d;
      uf_q     <= uf_d;
      ucnt_q   <= ucnt_d;
    end
  end

endmodule

// File: tb/tb_dsm_tx_sched.sv
// Directed bench for dsm_tx_sched with hand-computed expectations.
// Inputs change and outputs are sampled on the falling edge.
module tb_dsm_tx_sched;

  localparam int DW = 20;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic          flush = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] v_out;
  logic          sample_stb;
  logic [1:0]    LO;
  logic          running;
  logic          underflow;
  logic [7:0]    under_cnt;
  logic [2:0]    level;

  int n_cmp = 0;
  int n_bad = 0;

  dsm_tx_sched dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .flush      (flush),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .v_out      (v_out),
    .sample_stb (sample_stb),
    .LO         (LO),
    .running    (running),
    .underflow  (underflow),
    .under_cnt  (under_cnt),
    .level      (level)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] lo_exp(input int i);
    case (i % 4)
      0:       return 2'b01;
      2:       return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic push(input logic [DW-1:0] d);
    int n;
    n = 0;
    in_data  = d;
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) chk("push_timeout", 0, 1);
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic wait_run();
    int n;
    n = 0;
    while (!running && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("run_entry", running, 1);
  endtask

  initial begin
    repeat (2) @(negedge clock);
    chk("rst_vout", v_out, 0);
    chk("rst_stb", sample_stb, 0);
    chk("rst_lo", LO, 0);
    chk("rst_run", running, 0);
    chk("rst_uf", underflow, 0);
    chk("rst_ucnt", under_cnt, 0);
    chk("rst_level", level, 0);
    chk("rst_ready", in_ready, 1);
    reset = 1'b1;

    // Fill to full, then stream with backpressure and a stop.
    for (int k = 1; k <= 4; k++) push(DW'(k));
    chk("full_level", level, 4);
    chk("full_ready", in_ready, 0);
    chk("full_idle", running, 0);
    enable = 1'b1;
    fork
      begin
        for (int k = 5; k <= 11; k++) push(DW'(k));
      end
      begin
        wait_run();
        for (int i = 0; i <= 500; i++) begin
          if (i > 0) @(negedge clock);
          if (i < 500) begin
            chk("lo_seq", LO, lo_exp(i));
            if (i % 50 == 0) begin
              chk("stb_hi", sample_stb, 1);
              chk("v_seq", v_out, i / 50 + 1);
              chk("no_uf", underflow, 0);
            end else if (i % 50 == 1) begin
              chk("stb_lo", sample_stb, 0);
            end
            if (i == 120) enable = 1'b0;
            if (i == 130) enable = 1'b1;
            if (i == 151) chk("reenable_run", running, 1);
            if (i == 470) enable = 1'b0;
            if (i == 499) begin
              chk("stop_hold_v", v_out, 10);
              chk("stop_hold_run", running, 1);
            end
          end else begin
            chk("stop_run", running, 0);
            chk("stop_vout", v_out, 0);
            chk("stop_lo", LO, 0);
            chk("stop_stb", sample_stb, 0);
            chk("stop_level", level, 1);
            chk("stop_uf", underflow, 0);
          end
        end
      end
    join

    // Underflow and saturation; flush in RUN must be ignored.
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    chk("pre_flush_level", level, 0);
    push(20);
    push(21);
    enable = 1'b1;
    wait_run();
    chk("uf_v0", v_out, 20);
    chk("uf_stb0", sample_stb, 1);
    for (int i = 1; i <= 12900; i++) begin
      @(negedge clock);
      if (i == 25) flush = 1'b1;
      if (i == 26) begin
        flush = 1'b0;
        chk("run_flush_level", level, 1);
        chk("run_flush_run", running, 1);
      end
      if (i == 50) begin
        chk("uf_v1", v_out, 21);
        chk("uf_none", underflow, 0);
      end
      if (i == 100) begin
        chk("uf_vmute", v_out, 0);
        chk("uf_stb", sample_stb, 1);
        chk("uf_flag", underflow, 1);
        chk("uf_cnt1", under_cnt, 1);
        chk("uf_level", level, 0);
      end
      if (i == 150)   chk("uf_cnt2", under_cnt, 2);
      if (i == 12750) chk("uf_cnt254", under_cnt, 254);
      if (i == 12800) chk("uf_cnt255", under_cnt, 255);
      if (i == 12850) chk("uf_sat", under_cnt, 255);
      if (i == 12860) enable = 1'b0;
      if (i == 12900) begin
        chk("uf_stop_run", running, 0);
        chk("uf_stop_sat", under_cnt, 255);
      end
    end

    // Flush in IDLE with a coincident push.
    chk("fl_uf_before", underflow, 1);
    push(40);
    push(41);
    chk("fl_level_before", level, 2);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 99;
    @(negedge clock);
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_level", level, 0);
    chk("fl_uf", underflow, 0);
    chk("fl_ucnt", under_cnt, 255);
    chk("fl_ready", in_ready, 1);

    // Asynchronous reset in the middle of a frame.
    push(50);
    push(51);
    push(52);
    enable = 1'b1;
    wait_run();
    repeat (10) @(negedge clock);
    chk("pre_rst_v", v_out, 50);
    chk("pre_rst_lo", LO, 2'b10);
    #2 reset = 1'b0;
    #1;
    chk("arst_run", running, 0);
    chk("arst_vout", v_out, 0);
    chk("arst_lo", LO, 0);
    chk("arst_stb", sample_stb, 0);
    chk("arst_level", level, 0);
    chk("arst_ucnt", under_cnt, 0);
    chk("arst_uf", underflow, 0);
    chk("arst_ready", in_ready, 1);
    @(negedge clock);
    enable = 1'b0;
    reset  = 1'b1;
    repeat (5) @(negedge clock);
    chk("post_rst_idle", running, 0);
    chk("post_rst_lo", LO, 0);
    enable = 1'b1;
    push(60);
    repeat (3) @(negedge clock);
    chk("prime_hold", running, 0);
    chk("prime_level", level, 1);
    enable = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dsm_tx_sched.md
Name: dsm_tx_sched

Overview:
Sample scheduler and LO sequencer for the transmit path in front of the interpolator and mixer. It buffers baseband samples from an upstream valid/ready source in a small FIFO. In RUN it releases one sample to the interpolator every RATIO fast clocks and generates the 4-phase fs/4 LO code for the mixer, keeping both aligned to a common frame. It also handles start-up priming, orderly stop, flush and underflow detection/muting.

Parameters:
DW, 20, sample width (matches interpolator v_in)
RATIO, 50, fast clocks per input sample (interpolation ratio), >= 4
DEPTH, 4, FIFO depth in samples, power of 2
PRIME_LVL, 2, FIFO occupancy required before leaving PRIME, 1..DEPTH

Ports:
clock  in  1  fast datapath clock
reset  in  1  asynchronous, active-low reset
enable  in  1  level; 1 = stream, 0 = stop at next frame boundary
flush  in  1  1-cycle pulse; empties FIFO, clears underflow status; honoured only in IDLE
in_data  in  DW  upstream sample
in_valid  in  1  upstream sample valid
in_ready  out  1  FIFO can accept (= !full)
v_out  out  DW  sample to interpolator, held for a whole frame
sample_stb  out  1  1-cycle pulse: v_out has just changed
LO  out  2  mixer LO code: 01=+1, 00=0, 10=-1
running  out  1  1 while state is RUN
underflow  out  1  sticky: a frame load found the FIFO empty
under_cnt  out  8  saturating count of underflowed frame loads
level  out  clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; FIFO empty; v_out=0; sample_stb=0; LO=00; running=0; underflow=0; under_cnt=0; phase and LO counters 0.
- Push: accepted when in_valid && in_ready. A push and a pop on the same edge are both performed and leave level unchanged. in_ready depends only on the registered count, with no combinational path from in_valid.
- FSM, IDLE -> PRIME: enable=1.
- FSM, PRIME -> RUN: enable=1 && level >= PRIME_LVL.
- FSM, PRIME -> IDLE: enable=0.
- FSM, RUN -> IDLE: on a load edge with enable=0.
- Load edge: the transition edge into RUN, or any RUN edge with phase==RATIO-1.
- Phase counter: 0..RATIO-1, width clog2(RATIO). Cleared on RUN entry; +1 per clock in RUN; wraps RATIO-1 -> 0.
- Load edge while staying in RUN:
  - FIFO non-empty: pop; v_out <= head.
  - FIFO empty: v_out <= 0 (mute); underflow <= 1; under_cnt +1, saturating at 255.
  - sample_stb = 1 in the following cycle only.
- Load edge leaving RUN: no pop; v_out <= 0; no strobe; LO <= 00.
- Latency: first sample_stb occurs 1 cycle after PRIME->RUN; subsequent strobes follow every RATIO cycles.
- LO sequence:
  - 2-bit counter cleared on RUN entry, +1 per clock in RUN, wraps mod 4.
  - LO is registered, decoded from the counter: 0 -> 01, 1 -> 00, 2 -> 10, 3 -> 00.
  - First RUN cycle shows 01. LO is 00 outside RUN.
  - The LO counter is not re-cleared at frame boundaries, so phase continues across frames.
- enable falling mid-frame: the current frame completes; no truncation.
- enable rising again in the same frame it fell: no stop.
- flush in IDLE: level -> 0 and underflow -> 0 on the next edge; under_cnt is kept. A push coincident with flush is dropped.
- flush outside IDLE: ignored.
- Arithmetic: all counters unsigned. v_out is passed through with no arithmetic (two's-complement contents are untouched).

Test Plan:
- Basic stream: RATIO=50, push 10 samples 1..10, enable=1 -> RUN once level>=2; sample_stb every 50 cycles; v_out = 1,2,3…; LO = 01,00,10,00 repeating from first RUN cycle; no underflow.
- Underflow: push 2 samples only, keep enable=1 -> third load gives v_out=0, underflow=1, under_cnt=1; under_cnt increments once per later frame and saturates at 255.
- Stop mid-frame: drop enable at phase 20 -> v_out holds until phase 49 edge, then v_out=0, LO=00, running=0; no extra pop (level unchanged).
- Full backpressure: push DEPTH+2 samples in IDLE -> in_ready=0 after 4 accepted; level=4; 5th/6th held until first pop, then accepted in order.
- Flush: underflow=1 in IDLE, pulse flush with in_valid=1 -> level=0, underflow=0, under_cnt retained, pushed sample dropped; flush during RUN has no effect.
- Async reset mid-RUN: drive reset=0 between edges -> all outputs to reset values immediately; after release, IDLE until enable.
